// File: rtl/button_pkg.sv
// Shared parameters and types for the button event scheduler.
package button_pkg;

    localparam int unsigned N_BTN      = 25;
    localparam int unsigned BTN_ID_W   = 5;
    localparam int unsigned FIFO_DEPTH = 8;

    typedef logic [BTN_ID_W-1:0] btn_id_t;

endpackage : button_pkg

// File: rtl/btn_id_fifo.sv
// First-word-fall-through queue of button IDs with synchronous push/pop and occupancy output.
module btn_id_fifo
    import button_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  btn_id_t                i_data,
    input  logic                   i_pop,
    output logic                   o_valid,
    output btn_id_t                o_data,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    btn_id_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_c;
    logic          pop_c;

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign o_valid = (level_q != '0);
    assign pop_c   = i_pop & o_valid;
    assign push_c  = i_push & ((level_q != LW'(DEPTH)) | pop_c);
    assign o_data  = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_level = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; the head is masked while the queue is empty.
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule : btn_id_fifo

// File: rtl/button_event_scheduler.sv
// Latches button press pulses, grants one per cycle round-robin into an ID queue,
// and counts presses lost because the same button was still pending.
module button_event_scheduler
    import button_pkg::*;
#(
    parameter int unsigned N_BTN      = button_pkg::N_BTN,
    parameter int unsigned FIFO_DEPTH = button_pkg::FIFO_DEPTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_BTN-1:0]            i_pos,
    input  logic                        i_ready,
    output logic                        o_valid,
    output logic [BTN_ID_W-1:0]         o_btn_id,
    output logic [N_BTN-1:0]            o_pending,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic [7:0]                  o_drop_cnt
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] grant_c;
    logic [N_BTN-1:0] drop_c;
    btn_id_t          rr_ptr_q, rr_ptr_d;
    btn_id_t          cand_c;
    btn_id_t          grant_id_c;
    logic             grant_vld_c;
    logic             do_grant_c;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [8:0]       drop_sum_c;
    logic [LVL_W-1:0] level;
    logic             fifo_valid;
    btn_id_t          fifo_head;
    logic             pop_c;
    logic             can_push_c;

    assign pop_c      = fifo_valid & i_ready;
    assign can_push_c = (level < LVL_W'(FIFO_DEPTH)) | pop_c;
    assign do_grant_c = grant_vld_c & can_push_c;

    // Round-robin search starting one past the last granted index, wrapping at N_BTN-1.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        cand_c      = rr_ptr_q;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            cand_c = (cand_c == BTN_ID_W'(N_BTN - 1)) ? '0 : cand_c + BTN_ID_W'(1);
            if (!grant_vld_c && pending_q[cand_c]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = cand_c;
            end
        end
    end

    // A new press on the granted lane re-arms it; a press on any other pending lane is lost.
    always_comb begin
        grant_c = '0;
        if (do_grant_c) begin
            grant_c[grant_id_c] = 1'b1;
        end
        pending_d = (pending_q & ~grant_c) | i_pos;
        drop_c    = i_pos & pending_q & ~grant_c;
        rr_ptr_d  = do_grant_c ? grant_id_c : rr_ptr_q;
    end

    always_comb begin
        drop_sum_c = {1'b0, drop_cnt_q};
        for (int unsigned i = 0; i < N_BTN; i++) begin
            drop_sum_c = drop_sum_c + 9'(drop_c[i]);
        end
        drop_cnt_d = (drop_sum_c > 9'd255) ? 8'hFF : drop_sum_c[7:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q  <= '0;
            rr_ptr_q   <= BTN_ID_W'(N_BTN - 1);
            drop_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    btn_id_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (do_grant_c),
        .i_data  (grant_id_c),
        .i_pop   (pop_c),
        .o_valid (fifo_valid),
        .o_data  (fifo_head),
        .o_level (level)
    );

    assign o_valid    = fifo_valid;
    assign o_btn_id   = fifo_head;
    assign o_pending  = pending_q;
    assign o_level    = level;
    assign o_drop_cnt = drop_cnt_q;

endmodule : button_event_scheduler
